// File: rtl/plate_spawner_if.sv
// Bundles the spawner's control inputs and plate-pool outputs for the plate sprite stage.
// The master side is the spawner; the slave side is its consumer.
interface plate_spawner_if #(
  parameter int N_PLATES = 8,
  parameter int CW       = 20
);
  logic                   replay;
  logic                   frame;
  logic [CW-1:0]          screen_height;
  logic [N_PLATES*CW-1:0] plate_x_flat;
  logic [N_PLATES*CW-1:0] plate_y_flat;
  logic [CW-1:0]          top_y;
  logic                   busy;
  logic                   respawn;
  logic [3:0]             respawn_idx;

  modport master (
    input  replay, frame, screen_height,
    output plate_x_flat, plate_y_flat, top_y, busy, respawn, respawn_idx
  );

  modport slave (
    output replay, frame, screen_height,
    input  plate_x_flat, plate_y_flat, top_y, busy, respawn, respawn_idx
  );
endinterface

// File: rtl/plate_spawner.sv
// Owns the plate pool: builds the initial layout, then once per frame recycles off-screen plates above the top.
// INIT and SCAN each take N_PLATES cycles, one slot per cycle; there is no backpressure and a frame seen while busy is dropped.
module plate_spawner #(
  parameter int          N_PLATES     = 8,
  parameter int          CW           = 20,
  parameter int          PLATE_HEIGHT = 16,
  parameter int          X_RANGE      = 576,
  parameter int          BASE_Y       = 20,
  parameter int          INIT_GAP     = 60,
  parameter int          GAP_MIN      = 40,
  parameter int          GAP_BITS     = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic           clk,
  input  logic           i_rst_n,
  plate_spawner_if.master bus
);

  localparam int         IW       = (N_PLATES > 1) ? $clog2(N_PLATES) : 1;
  localparam logic [3:0] LAST_IDX = 4'(N_PLATES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SCAN
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [CW-1:0] x_q [N_PLATES];
  logic [CW-1:0] x_d [N_PLATES];
  logic [CW-1:0] y_q [N_PLATES];
  logic [CW-1:0] y_d [N_PLATES];
  logic [CW-1:0] top_y_q, top_y_d;
  logic [CW-1:0] sh_q, sh_d;
  logic          respawn_q, respawn_d;
  logic [3:0]    respawn_idx_q, respawn_idx_d;

  logic [IW-1:0] sel;
  logic [9:0]    r_lo;
  logic [9:0]    xr_lo;
  logic [CW-1:0] xr;
  logic [CW-1:0] gap;
  logic [CW-1:0] init_y;
  logic [CW-1:0] new_top;
  logic          off_screen;
  logic          last;
  logic          lfsr_fb;

  assign sel = idx_q[IW-1:0];

  // Random x folds the 10-bit LFSR slice into 0..X_RANGE-1 with a single subtract.
  always_comb begin
    r_lo       = lfsr_q[9:0];
    xr_lo      = (r_lo < 10'(X_RANGE)) ? r_lo : r_lo - 10'(X_RANGE);
    xr         = CW'(xr_lo);
    gap        = CW'(GAP_MIN) + CW'(lfsr_q[15 -: GAP_BITS]);
    init_y     = CW'(BASE_Y) + CW'(INIT_GAP) * CW'(idx_q);
    new_top    = top_y_q + gap;
    off_screen = ({1'b0, y_q[sel]} + (CW+1)'(PLATE_HEIGHT)) < {1'b0, sh_q};
    last       = (idx_q == LAST_IDX);
    lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    lfsr_d        = (state_q != ST_IDLE) ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
    x_d           = x_q;
    y_d           = y_q;
    top_y_d       = top_y_q;
    sh_d          = sh_q;
    respawn_d     = 1'b0;
    respawn_idx_d = respawn_idx_q;

    if (bus.replay) begin
      lfsr_d  = LFSR_SEED;
      idx_d   = '0;
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: begin
          x_d[sel] = xr;
          y_d[sel] = init_y;
          if (last) begin
            top_y_d = init_y;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        ST_IDLE: begin
          if (bus.frame) begin
            idx_d   = '0;
            sh_d    = bus.screen_height;
            state_d = ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Chained recycles stack on the freshly updated top, keeping heights increasing.
          if (off_screen) begin
            x_d[sel]      = xr;
            y_d[sel]      = new_top;
            top_y_d       = new_top;
            respawn_d     = 1'b1;
            respawn_idx_d = idx_q;
          end
          if (last) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          idx_d   = '0;
          state_d = ST_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      for (int i = 0; i < N_PLATES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      top_y_q       <= '0;
      sh_q          <= '0;
      respawn_q     <= 1'b0;
      respawn_idx_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lfsr_q        <= lfsr_d;
      x_q           <= x_d;
      y_q           <= y_d;
      top_y_q       <= top_y_d;
      sh_q          <= sh_d;
      respawn_q     <= respawn_d;
      respawn_idx_q <= respawn_idx_d;
    end
  end

  for (genvar g = 0; g < N_PLATES; g++) begin : g_flat
    assign bus.plate_x_flat[g*CW +: CW] = x_q[g];
    assign bus.plate_y_flat[g*CW +: CW] = y_q[g];
  end

  assign bus.top_y       = top_y_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.respawn     = respawn_q;
  assign bus.respawn_idx = respawn_idx_q;

endmodule

// File: tb/tb_plate_spawner.sv
// Directed bench for plate_spawner with an independent LFSR/layout model and a respawn scoreboard.
module tb_plate_spawner;

  localparam int N  = 8;
  localparam int CW = 20;

  typedef struct {
    int          idx;
    logic [19:0] x;
    logic [19:0] y;
    logic [19:0] top;
  } resp_t;

  logic clk;
  logic i_rst_n;

  int total = 0;
  int bad   = 0;

  logic [19:0] mx [N];
  logic [19:0] my [N];
  logic [19:0] mtop;
  logic [15:0] mlfsr;
  resp_t       exp_q [$];

  plate_spawner_if #(.N_PLATES(N), .CW(CW)) bus ();

  plate_spawner dut (
    .clk    (clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] r);
    return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
  endfunction

  function automatic logic [19:0] xr_of(input logic [15:0] r);
    int v;
    v = int'(r[9:0]);
    if (v >= 576) v = v - 576;
    return 20'(v);
  endfunction

  function automatic logic [19:0] gap_of(input logic [15:0] r);
    return 20'(40 + int'(r[15:11]));
  endfunction

  function automatic logic [19:0] slot_x(input int i);
    return bus.plate_x_flat[i*CW +: CW];
  endfunction

  function automatic logic [19:0] slot_y(input int i);
    return bus.plate_y_flat[i*CW +: CW];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_init();
    mlfsr = 16'hACE1;
    for (int i = 0; i < N; i++) begin
      my[i] = 20'(20 + i * 60);
      mx[i] = xr_of(mlfsr);
      mlfsr = lfsr_step(mlfsr);
    end
    mtop = 20'd440;
  endtask

  task automatic model_scan(input logic [19:0] sh);
    resp_t e;
    for (int i = 0; i < N; i++) begin
      if (({1'b0, my[i]} + 21'd16) < {1'b0, sh}) begin
        mtop  = mtop + gap_of(mlfsr);
        my[i] = mtop;
        mx[i] = xr_of(mlfsr);
        e.idx = i;
        e.x   = mx[i];
        e.y   = my[i];
        e.top = mtop;
        exp_q.push_back(e);
      end
      mlfsr = lfsr_step(mlfsr);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), slot_x(i), mx[i]);
      chk($sformatf("%s_y%0d", tag, i), slot_y(i), my[i]);
    end
    chk({tag, "_top"}, bus.top_y, mtop);
  endtask

  task automatic pulse_frame();
    bus.frame = 1'b1;
    @(posedge clk);
    #1 bus.frame = 1'b0;
  endtask

  task automatic pulse_replay();
    bus.replay = 1'b1;
    @(posedge clk);
    #1 bus.replay = 1'b0;
  endtask

  // Samples 1 time unit after each rising edge until busy falls, scoring respawn pulses.
  task automatic collect(input int sh_at, input logic [19:0] sh_new, input int stray_at,
                         input int replay_at, output int nbusy, output int npulse);
    resp_t e;
    bit    seen;
    nbusy  = 0;
    npulse = 0;
    seen   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c == sh_at) bus.screen_height = sh_new;
      bus.frame  = (c == stray_at);
      bus.replay = (c == replay_at);
      if (bus.respawn) begin
        npulse++;
        if (exp_q.size() == 0) begin
          chk("spurious_respawn", 32'(bus.respawn), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("respawn_idx", 32'(bus.respawn_idx), 32'(e.idx));
          chk("respawn_y", slot_y(e.idx), e.y);
          chk("respawn_x", slot_x(e.idx), e.x);
          chk("respawn_top", bus.top_y, e.top);
        end
      end
      if (bus.busy) begin
        nbusy++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.frame  = 1'b0;
    bus.replay = 1'b0;
  endtask

  initial begin
    int          nb;
    int          np;
    logic [19:0] g0;
    logic [19:0] g1;

    i_rst_n           = 1'b0;
    bus.replay        = 1'b0;
    bus.frame         = 1'b0;
    bus.screen_height = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_x", slot_x(i), 20'd0);
      chk("rst_y", slot_y(i), 20'd0);
    end
    chk("rst_top", bus.top_y, 20'd0);
    chk("rst_respawn", 32'(bus.respawn), 32'd0);

    // Initial layout straight out of reset.
    i_rst_n = 1'b1;
    model_init();
    collect(-1, '0, -1, -1, nb, np);
    chk("init_busy", nb, 8);
    chk("init_pulses", np, 0);
    check_all("init");
    for (int i = 0; i < N; i++) chk("init_x_range", 32'(slot_x(i) < 20'd576), 32'd1);

    // Nothing below the window.
    bus.screen_height = 20'd0;
    pulse_frame();
    model_scan(20'd0);
    collect(-1, '0, -1, -1, nb, np);
    chk("sh0_busy", nb, 8);
    chk("sh0_pulses", np, 0);
    check_all("sh0");

    // Equality boundary: slot 1 sits exactly at the bottom edge and stays.
    bus.screen_height = 20'd96;
    pulse_frame();
    model_scan(20'd96);
    collect(-1, '0, -1, -1, nb, np);
    chk("sh96_pulses", np, 1);
    chk("sh96_slot1_kept", slot_y(1), 20'd80);
    check_all("sh96");

    pulse_replay();
    model_init();
    collect(-1, '0, -1, -1, nb, np);
    chk("replay_busy", nb, 8);
    chk("replay_pulses", np, 0);
    check_all("replay");

    // Two chained recycles; the live screen_height moves mid-scan and must be ignored.
    bus.screen_height = 20'd97;
    pulse_frame();
    model_scan(20'd97);
    collect(2, 20'hFFFFF, -1, -1, nb, np);
    chk("sh97_busy", nb, 8);
    chk("sh97_pulses", np, 2);
    check_all("sh97");
    g0 = slot_y(0) - 20'd440;
    g1 = slot_y(1) - slot_y(0);
    chk("sh97_gap0_range", 32'(g0 >= 20'd40 && g0 <= 20'd71), 32'd1);
    chk("sh97_gap1_range", 32'(g1 >= 20'd40 && g1 <= 20'd71), 32'd1);
    chk("sh97_top_is_y1", bus.top_y, slot_y(1));

    // A stray frame mid-scan is dropped, not queued.
    bus.screen_height = 20'd0;
    pulse_frame();
    model_scan(20'd0);
    collect(-1, '0, 3, -1, nb, np);
    chk("stray_busy", nb, 8);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("stray_idle", 32'(bus.busy), 32'd0);
    end
    check_all("stray");

    // Replay mid-scan restarts the layout from the seed.
    pulse_frame();
    collect(-1, '0, -1, 3, nb, np);
    chk("replay_mid_busy", nb, 12);
    chk("replay_mid_pulses", np, 0);
    model_init();
    check_all("replay_mid");

    // Async reset in the middle of a recycling scan.
    bus.screen_height = 20'd300;
    pulse_frame();
    model_scan(20'd300);
    repeat (3) @(posedge clk);
    #3 i_rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk("arst_x", slot_x(i), 20'd0);
      chk("arst_y", slot_y(i), 20'd0);
    end
    chk("arst_top", bus.top_y, 20'd0);
    chk("arst_respawn", 32'(bus.respawn), 32'd0);
    exp_q.delete();
    bus.screen_height = 20'd0;
    @(negedge clk);
    i_rst_n = 1'b1;
    model_init();
    collect(-1, '0, -1, -1, nb, np);
    chk("arst_init_busy", nb, 8);
    chk("arst_init_pulses", np, 0);
    check_all("arst_init");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plate_spawner.md
Name: plate_spawner

Overview:
- Upstream of the per-plate sprite stage. Owns the world coordinates (plate_x_init, plate_y_init) of a fixed pool of N_PLATES plates and feeds them to the plate instances.
- Once per frame it scans the pool. Any plate that has scrolled below the visible window, given the current scroll offset screen_height, is recycled to a new pseudo-random position above the current highest plate.
- Also generates the initial layout after reset and after replay.

Parameters:
- N_PLATES, 8, number of plate slots; must be 2..16.
- CW, 20, coordinate width; matches plate_x_init and plate_y_init.
- PLATE_HEIGHT, 16, plate height in pixels, used for the off-screen test.
- X_RANGE, 576, legal x positions 0..X_RANGE-1 (640 minus plate width 64).
- BASE_Y, 20, world y of slot 0 in the initial layout.
- INIT_GAP, 60, world y spacing between consecutive slots in the initial layout.
- GAP_MIN, 40, minimum vertical gap on respawn.
- GAP_BITS, 5, random gap add-on width; gap = GAP_MIN + 0..(2^GAP_BITS - 1).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- replay  in  1  synchronous restart pulse; re-runs the initial layout.
- frame  in  1  single-cycle pulse at start of vertical blank.
- screen_height  in  CW  current world scroll offset; the bottom of the screen is at world y = screen_height.
- plate_x_flat  out  N_PLATES*CW  slot i x in bits [i*CW +: CW].
- plate_y_flat  out  N_PLATES*CW  slot i world y (bg_height) in bits [i*CW +: CW].
- top_y  out  CW  highest world y currently in the pool.
- busy  out  1  high while in INIT or SCAN.
- respawn  out  1  one-cycle pulse per slot recycled.
- respawn_idx  out  4  slot index valid when respawn is high.

Behaviour:

LFSR:
- 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting left with feedback into bit 0.
- Advances every cycle while busy=1; holds otherwise.
- Set to LFSR_SEED on reset and on replay.

Random values (combinational from the current LFSR value r):
- xr = r[9:0] if r[9:0] < X_RANGE, else r[9:0] - X_RANGE. The result is always < X_RANGE.
- gap = GAP_MIN + r[15:16-GAP_BITS].

FSM states: INIT, IDLE, SCAN.
- Async reset:
  - All plate_x and plate_y = 0, top_y = 0, respawn = 0, idx = 0, LFSR = seed.
  - State = INIT, so busy = 1 in the first cycle after reset release.
- INIT, one slot per cycle, idx 0..N_PLATES-1:
  - y[idx] <= BASE_Y + idx*INIT_GAP; x[idx] <= xr.
  - At idx = N_PLATES-1: top_y <= BASE_Y + (N_PLATES-1)*INIT_GAP, go to IDLE.
  - Duration is exactly N_PLATES cycles.
  - respawn is not pulsed in INIT.
- IDLE:
  - busy = 0.
  - On frame: idx <= 0, capture sh <= screen_height, go to SCAN.
- SCAN, one slot per cycle, idx 0..N_PLATES-1:
  - The off-screen test is y[idx] + PLATE_HEIGHT < sh, evaluated at CW+1 bits (no overflow).
  - If off-screen: y[idx] <= top_y + gap; x[idx] <= xr; top_y <= top_y + gap (registered); respawn = 1; respawn_idx = idx.
  - If several slots recycle in one scan, each uses the top_y updated by the previous recycle, so heights stay strictly increasing.
  - At idx = N_PLATES-1: go to IDLE. The scan takes exactly N_PLATES cycles.
- respawn and respawn_idx are registered. The pulse appears in the cycle after the slot is evaluated, and updated outputs are visible in that same cycle.

Boundary conditions:
- Equality is not off-screen: y + PLATE_HEIGHT == sh keeps the plate.
- A frame pulse during INIT or SCAN is ignored and not queued.
- A screen_height change during SCAN has no effect, because the scan uses sh.
- replay in any state: LFSR = seed, idx = 0, state = INIT, respawn = 0. replay has priority over frame in the same cycle.
- top_y + gap wraps modulo 2^CW; no saturation.
- An async reset mid-scan aborts the scan immediately, sets the reset values, and restarts from INIT.
- Outputs change only during busy, which falls inside vblank, so the downstream plate sprites see stable coordinates during active video.

Test Plan:
1. Reset release, defaults (N=8) -> busy high for exactly 8 cycles. plate_y = 20,80,...,440. top_y = 440. Every x < 576 and equal to the LFSR reference model. No respawn pulses.
2. IDLE, screen_height = 0, frame pulse -> busy for 8 cycles, zero respawn pulses, all coordinates unchanged.
3. screen_height = 97, frame pulse -> slots 0 (20+16 < 97) and 1 (80+16 = 96 < 97) recycle. Two respawn pulses with idx 0 then 1. New y[0] = 440 + g0, y[1] = 440 + g0 + g1. Each gap is in 40..71. top_y = y[1].
4. screen_height = 96, where slot 1 satisfies y + 16 == 96 -> only slot 0 recycles; slot 1 is retained.
5. A second frame pulse 3 cycles into a scan -> ignored. A replay pulse mid-scan -> INIT restarts, and the layout is bit-identical to scenario 1.
6. Async reset asserted mid-scan -> all outputs 0 immediately. After release, identical to scenario 1.
